// File: rtl/reg_arb_ctrl.sv
// Round-robin arbiter for a shared register with per-requester lock, level clear
// and registered grant/write/clear outputs.
module reg_arb_ctrl #(
   parameter int unsigned BITWIDTH = 32,
   parameter int unsigned NREQ     = 4,
   parameter int unsigned MAXLOCK  = 4
) (
   input  logic                     iClk,
   input  logic                     iRstN,
   input  logic [NREQ-1:0]          iReq,
   input  logic [NREQ-1:0]          iLock,
   input  logic [NREQ*BITWIDTH-1:0] iData,
   input  logic                     iClr,
   output logic [NREQ-1:0]          oGnt,
   output logic                     oRegEn,
   output logic                     oRegClr,
   output logic [BITWIDTH-1:0]      oRegData,
   output logic [$clog2(NREQ)-1:0]  oOwner
);

   localparam int unsigned PW = $clog2(NREQ);
   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {IDLE, GRANT, LOCK, CLEAR} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [PW-1:0]       r_ptr;
   logic [PW-1:0]       r_owner;
   logic [CW-1:0]       r_lock_cnt;
   logic [CW-1:0]       w_cnt_nxt;
   logic [NREQ-1:0]     r_gnt;
   logic                r_reg_en;
   logic                r_reg_clr;
   logic [BITWIDTH-1:0] r_reg_data;

   logic                w_rr_found;
   logic [PW-1:0]       w_rr_idx;
   logic                w_lock_ok;
   logic                w_grant;
   logic [PW-1:0]       w_sel;
   logic [NREQ-1:0]     w_gnt_nxt;
   logic [BITWIDTH-1:0] w_sel_data;

   // First requester after the last granted index wins.
   always_comb begin
      w_rr_found = 1'b0;
      w_rr_idx   = r_ptr;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         if (!w_rr_found && iReq[PW'((32'(r_ptr) + i) % NREQ)]) begin
            w_rr_found = 1'b1;
            w_rr_idx   = PW'((32'(r_ptr) + i) % NREQ);
         end
      end
   end

   // The lock survives only across back-to-back grants to the same owner.
   assign w_lock_ok = ((r_state == GRANT) || (r_state == LOCK)) &&
                      iReq[r_owner] && iLock[r_owner] &&
                      (r_lock_cnt < CW'(MAXLOCK));

   always_comb begin
      w_state_nxt = IDLE;
      w_grant     = 1'b0;
      w_sel       = r_owner;
      w_cnt_nxt   = '0;
      if (iClr) begin
         w_state_nxt = CLEAR;
      end else if (w_lock_ok) begin
         w_state_nxt = LOCK;
         w_grant     = 1'b1;
         w_sel       = r_owner;
         w_cnt_nxt   = CW'(r_lock_cnt + CW'(1));
      end else if (w_rr_found) begin
         w_state_nxt = GRANT;
         w_grant     = 1'b1;
         w_sel       = w_rr_idx;
         w_cnt_nxt   = CW'(1);
      end
   end

   always_comb begin
      w_gnt_nxt  = '0;
      w_sel_data = iData[BITWIDTH-1:0];
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (w_sel == PW'(k)) begin
            w_gnt_nxt[k] = w_grant;
            w_sel_data   = iData[k*BITWIDTH +: BITWIDTH];
         end
      end
   end

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Pointer, owner and data move only on a grant; a clear leaves them alone.
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         r_ptr      <= PW'(NREQ - 1);
         r_owner    <= '0;
         r_lock_cnt <= '0;
         r_gnt      <= '0;
         r_reg_en   <= 1'b0;
         r_reg_clr  <= 1'b0;
         r_reg_data <= '0;
      end else begin
         r_lock_cnt <= w_cnt_nxt;
         r_gnt      <= w_gnt_nxt;
         r_reg_en   <= w_grant;
         r_reg_clr  <= (w_state_nxt == CLEAR);
         if (w_grant) begin
            r_ptr      <= w_sel;
            r_owner    <= w_sel;
            r_reg_data <= w_sel_data;
         end
      end
   end

   assign oGnt     = r_gnt;
   assign oRegEn   = r_reg_en;
   assign oRegClr  = r_reg_clr;
   assign oRegData = r_reg_data;
   assign oOwner   = r_owner;

endmodule

// File: tb/tb_reg_arb_ctrl.sv
// Scoreboard bench for reg_arb_ctrl: directed stimulus pushes expected
// grant/clear events, a negedge monitor pops and compares them.
module tb_reg_arb_ctrl;

   typedef struct packed {
      logic [3:0]  gnt;
      logic        en;
      logic        clr;
      logic [31:0] data;
      logic [1:0]  owner;
   } obs_t;

   logic         clk;
   logic         rst_n;
   logic [3:0]   req;
   logic [3:0]   lock;
   logic [127:0] data;
   logic         clr;
   logic [3:0]   gnt;
   logic         reg_en;
   logic         reg_clr;
   logic [31:0]  reg_data;
   logic [1:0]   owner;

   obs_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   reg_arb_ctrl #(.BITWIDTH(32), .NREQ(4), .MAXLOCK(4)) dut (
      .iClk     (clk),
      .iRstN    (rst_n),
      .iReq     (req),
      .iLock    (lock),
      .iData    (data),
      .iClr     (clr),
      .oGnt     (gnt),
      .oRegEn   (reg_en),
      .oRegClr  (reg_clr),
      .oRegData (reg_data),
      .oOwner   (owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic obs_t mk(logic [3:0] g, logic c, logic [31:0] d, logic [1:0] o);
      obs_t r;
      r.gnt   = g;
      r.en    = |g;
      r.clr   = c;
      r.data  = d;
      r.owner = o;
      return r;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(logic [31:0] base);
      for (int k = 0; k < 4; k++) data[k*32 +: 32] = base + 32'(k);
   endtask

   task automatic chk_zero(string tag);
      chk({tag, "_gnt"},   64'(gnt),      64'h0);
      chk({tag, "_en"},    64'(reg_en),   64'h0);
      chk({tag, "_clr"},   64'(reg_clr),  64'h0);
      chk({tag, "_data"},  64'(reg_data), 64'h0);
      chk({tag, "_owner"}, 64'(owner),    64'h0);
   endtask

   // Monitor: every grant or clear the DUT presents must match the next expectation.
   always @(negedge clk) begin
      obs_t act;
      obs_t e;
      if (reg_en || reg_clr) begin
         act = {gnt, reg_en, reg_clr, reg_data, owner};
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL sb_unexpected: got %h expected no event", act);
         end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
               n_errors++;
               $display("FAIL sb_event: got gnt=%b en=%b clr=%b data=%h owner=%0d expected gnt=%b en=%b clr=%b data=%h owner=%0d",
                        act.gnt, act.en, act.clr, act.data, act.owner,
                        e.gnt, e.en, e.clr, e.data, e.owner);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      req   = '0;
      lock  = '0;
      clr   = 1'b0;
      data  = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      rst_n = 1'b1;

      // Plain round-robin with all four requesting
      set_data(32'h1111_0000);
      req = 4'b1111;
      exp_q.push_back(mk(4'b0001, 1'b0, 32'h1111_0000, 2'd0));
      exp_q.push_back(mk(4'b0010, 1'b0, 32'h1111_0001, 2'd1));
      exp_q.push_back(mk(4'b0100, 1'b0, 32'h1111_0002, 2'd2));
      exp_q.push_back(mk(4'b1000, 1'b0, 32'h1111_0003, 2'd3));
      exp_q.push_back(mk(4'b0001, 1'b0, 32'h1111_0000, 2'd0));
      repeat (5) tick();
      req = '0;
      tick();
      tick();
      chk("idle_gnt", 64'(gnt), 64'h0);
      chk("idle_en", 64'(reg_en), 64'h0);
      chk("idle_data_held", 64'(reg_data), 64'h1111_0000);

      // Single request from requester 3
      data[3*32 +: 32] = 32'hDEAD_BEEF;
      req = 4'b1000;
      exp_q.push_back(mk(4'b1000, 1'b0, 32'hDEAD_BEEF, 2'd3));
      tick();
      chk("single_gnt", 64'(gnt), 64'h8);
      req = '0;
      tick();
      chk("single_en_drop", 64'(reg_en), 64'h0);
      chk("single_data_held", 64'(reg_data), 64'hDEAD_BEEF);
      chk("single_owner", 64'(owner), 64'h3);

      // Lock on requester 2 with requester 0 competing
      set_data(32'h2222_0000);
      req  = 4'b0100;
      lock = 4'b0100;
      exp_q.push_back(mk(4'b0100, 1'b0, 32'h2222_0002, 2'd2));
      tick();
      req = 4'b0101;
      exp_q.push_back(mk(4'b0100, 1'b0, 32'h2222_0002, 2'd2));
      exp_q.push_back(mk(4'b0100, 1'b0, 32'h2222_0002, 2'd2));
      exp_q.push_back(mk(4'b0100, 1'b0, 32'h2222_0002, 2'd2));
      exp_q.push_back(mk(4'b0001, 1'b0, 32'h2222_0000, 2'd0));
      repeat (4) tick();
      req = 4'b0100;
      exp_q.push_back(mk(4'b0100, 1'b0, 32'h2222_0002, 2'd2));
      tick();
      req  = '0;
      lock = '0;
      tick();

      // Clear held two cycles with requests pending
      clr = 1'b1;
      req = 4'b0011;
      exp_q.push_back(mk(4'b0000, 1'b1, 32'h2222_0002, 2'd2));
      exp_q.push_back(mk(4'b0000, 1'b1, 32'h2222_0002, 2'd2));
      repeat (2) tick();
      clr = 1'b0;
      exp_q.push_back(mk(4'b0001, 1'b0, 32'h2222_0000, 2'd0));
      exp_q.push_back(mk(4'b0010, 1'b0, 32'h2222_0001, 2'd1));
      repeat (2) tick();
      req = '0;
      tick();

      // Clear and request rising together
      clr = 1'b1;
      req = 4'b0010;
      exp_q.push_back(mk(4'b0000, 1'b1, 32'h2222_0001, 2'd1));
      tick();
      clr = 1'b0;
      exp_q.push_back(mk(4'b0010, 1'b0, 32'h2222_0001, 2'd1));
      tick();
      req = '0;
      tick();

      // Asynchronous reset while locked
      set_data(32'h3333_0000);
      req  = 4'b0100;
      lock = 4'b0100;
      exp_q.push_back(mk(4'b0100, 1'b0, 32'h3333_0002, 2'd2));
      tick();
      tick();
      chk("lock_regrant", 64'(gnt), 64'h4);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("async_rst");
      req  = 4'b1111;
      lock = '0;
      @(posedge clk);
      #1;
      chk("rst_no_gnt", 64'(gnt), 64'h0);
      rst_n = 1'b1;
      exp_q.push_back(mk(4'b0001, 1'b0, 32'h3333_0000, 2'd0));
      tick();
      req = '0;
      tick();
      tick();

      chk("sb_drained", 64'(exp_q.size()), 64'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
